// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC register, single-outstanding imem read, decode handshake
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] current_pc,
    input  logic [XLEN-1:0] npc,
    input  logic            redirect,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] current_pc_q, current_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;

    logic req_fire;
    logic id_fire;

    // Request is held low during reset even though the state register already reads REQ.
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = {current_pc_q[XLEN-1:2], 2'b00};
    assign current_pc     = current_pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign id_fire  = id_valid_q && id_ready;

    always_comb begin
        state_d      = state_q;
        current_pc_d = current_pc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        if (redirect) begin
            // Redirect wins over every other event; a fired read becomes an orphan to drain in DROP.
            current_pc_d = npc;
            id_valid_d   = 1'b0;
            case (state_q)
                S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        id_pc_d    = current_pc_q;
                        id_inst_d  = imem_rsp_data;
                        id_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (id_fire) begin
                        current_pc_d = npc;
                        id_valid_d   = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            current_pc_q <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_inst_q    <= '0;
        end else begin
            state_q      <= state_d;
            current_pc_q <= current_pc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_inst_q    <= id_inst_d;
        end
    end

    a_rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (state_q == S_REQ || state_q == S_HOLD)))
        else $error("imem_rsp_valid with no read outstanding");

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - cycle table, backpressure sequence and randomized model check for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_pc;
    logic [31:0] npc;
    logic        redirect;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int n_vec = 0;
    int n_bad = 0;

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .current_pc     (current_pc),
        .npc            (npc),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] npc;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        idr;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic r, input logic rd, input logic [31:0] n, input logic rq_rdy,
                         input logic rv, input logic [31:0] rdat, input logic ir);
        @(negedge clk);
        rst            = r;
        redirect       = rd;
        npc            = n;
        imem_req_ready = rq_rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rdat;
        id_ready       = ir;
        #1;
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
    endfunction

    logic [31:0] mpc;
    logic        mem_out;
    int          mem_lat;
    logic [31:0] mem_data;
    int          ndeliv;
    logic        r_redir, r_rdy, r_idr, r_rspv;
    logic [31:0] r_npc;

    initial begin
        rst = 1'b1; redirect = 1'b0; npc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;

        // rst, redir, npc, rdy, rspv, rspd, idr | rqv, addr, idv, idpc, inst, pc
        tbl.push_back(vec_t'{1, 0, 32'h000, 0, 0, 32'h0,         0, 0, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h004, 0, 0, 32'h0,         0, 1, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h004, 1, 0, 32'h0,         1, 1, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h004, 0, 1, 32'h13,        1, 0, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h004, 0, 0, 32'h0,         1, 0, 32'h000, 1, 32'h000, 32'h13,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h008, 1, 0, 32'h0,         1, 1, 32'h004, 0, 32'h000, 32'h13,       32'h004});
        tbl.push_back(vec_t'{0, 0, 32'h008, 0, 1, 32'h13,        1, 0, 32'h004, 0, 32'h000, 32'h13,       32'h004});
        tbl.push_back(vec_t'{0, 0, 32'h008, 0, 0, 32'h0,         1, 0, 32'h004, 1, 32'h004, 32'h13,       32'h004});
        tbl.push_back(vec_t'{0, 0, 32'h00C, 1, 0, 32'h0,         1, 1, 32'h008, 0, 32'h004, 32'h13,       32'h008});
        tbl.push_back(vec_t'{0, 0, 32'h00C, 0, 1, 32'h13,        1, 0, 32'h008, 0, 32'h004, 32'h13,       32'h008});
        tbl.push_back(vec_t'{0, 0, 32'h00C, 0, 0, 32'h0,         1, 0, 32'h008, 1, 32'h008, 32'h13,       32'h008});
        tbl.push_back(vec_t'{0, 0, 32'h010, 0, 0, 32'h0,         1, 1, 32'h00C, 0, 32'h008, 32'h13,       32'h00C});
        tbl.push_back(vec_t'{0, 0, 32'h010, 1, 0, 32'h0,         1, 1, 32'h00C, 0, 32'h008, 32'h13,       32'h00C});
        tbl.push_back(vec_t'{0, 1, 32'h040, 0, 1, 32'hDEADBEEF,  1, 0, 32'h00C, 0, 32'h008, 32'h13,       32'h00C});
        tbl.push_back(vec_t'{0, 0, 32'h044, 1, 0, 32'h0,         1, 1, 32'h040, 0, 32'h008, 32'h13,       32'h040});
        tbl.push_back(vec_t'{0, 1, 32'h100, 0, 0, 32'h0,         1, 0, 32'h040, 0, 32'h008, 32'h13,       32'h040});
        tbl.push_back(vec_t'{0, 0, 32'h104, 0, 0, 32'h0,         1, 0, 32'h100, 0, 32'h008, 32'h13,       32'h100});
        tbl.push_back(vec_t'{0, 0, 32'h104, 0, 1, 32'hBAD00001,  1, 0, 32'h100, 0, 32'h008, 32'h13,       32'h100});
        tbl.push_back(vec_t'{0, 0, 32'h104, 1, 0, 32'h0,         1, 1, 32'h100, 0, 32'h008, 32'h13,       32'h100});
        tbl.push_back(vec_t'{0, 0, 32'h104, 0, 1, 32'h93,        0, 0, 32'h100, 0, 32'h008, 32'h13,       32'h100});
        tbl.push_back(vec_t'{0, 1, 32'h080, 0, 0, 32'h0,         1, 0, 32'h100, 1, 32'h100, 32'h93,       32'h100});
        tbl.push_back(vec_t'{0, 0, 32'h084, 1, 0, 32'h0,         1, 1, 32'h080, 0, 32'h100, 32'h93,       32'h080});
        tbl.push_back(vec_t'{1, 0, 32'h084, 0, 0, 32'h0,         1, 0, 32'h080, 0, 32'h100, 32'h93,       32'h080});
        tbl.push_back(vec_t'{0, 0, 32'h004, 0, 0, 32'h0,         0, 1, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 1, 32'h203, 0, 0, 32'h0,         0, 1, 32'h000, 0, 32'h000, 32'h00,       32'h000});
        tbl.push_back(vec_t'{0, 0, 32'h207, 0, 0, 32'h0,         0, 1, 32'h200, 0, 32'h000, 32'h00,       32'h203});

        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].npc, tbl[i].rdy, tbl[i].rspv, tbl[i].rspd, tbl[i].idr);
            chk($sformatf("v%0d.req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rqv));
            if (tbl[i].e_rqv) chk($sformatf("v%0d.req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.id_valid", i), 32'(id_valid), 32'(tbl[i].e_idv));
            chk($sformatf("v%0d.id_pc", i), id_pc, tbl[i].e_idpc);
            chk($sformatf("v%0d.id_inst", i), id_inst, tbl[i].e_inst);
            chk($sformatf("v%0d.current_pc", i), current_pc, tbl[i].e_pc);
        end

        // Backpressure in HOLD: fetch at 0x203, then hold id_ready low with memory willing.
        drive(0, 0, 32'h207, 1, 0, 0, 0);
        drive(0, 0, 32'h207, 0, 1, 32'h33, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 32'h207, 1, 0, 0, (k == 5));
            chk("bp.id_valid", 32'(id_valid), 32'd1);
            chk("bp.id_pc", id_pc, 32'h203);
            chk("bp.id_inst", id_inst, 32'h33);
            chk("bp.no_req", 32'(imem_req_valid), 32'd0);
            chk("bp.current_pc", current_pc, 32'h203);
        end
        drive(0, 0, 32'h20B, 0, 0, 0, 0);
        chk("bp.after.req_valid", 32'(imem_req_valid), 32'd1);
        chk("bp.after.req_addr", imem_req_addr, 32'h204);
        chk("bp.after.current_pc", current_pc, 32'h207);

        // Randomized run against a transaction-level PC model and a one-deep memory.
        drive(1, 0, 0, 0, 0, 0, 0);
        mpc = 32'h0; mem_out = 1'b0; mem_lat = 0; mem_data = '0; ndeliv = 0;
        for (int c = 0; c < 3000; c++) begin
            r_rspv = mem_out && (mem_lat == 0);
            if (mem_out && mem_lat != 0) mem_lat--;
            r_redir = ($urandom_range(0, 99) < 12);
            r_npc   = r_redir ? ($urandom & 32'h0000_FFFF) : mpc + 32'd4;
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_idr   = ($urandom_range(0, 9) < 6);
            drive(0, r_redir, r_npc, r_rdy, r_rspv, r_rspv ? mem_data : $urandom, r_idr);
            chk("rnd.current_pc", current_pc, mpc);
            if (imem_req_valid) begin
                chk("rnd.req_addr", imem_req_addr, {mpc[31:2], 2'b00});
                chk("rnd.single_outstanding", 32'(mem_out), 32'd0);
            end
            if (id_valid) begin
                chk("rnd.id_pc", id_pc, mpc);
                chk("rnd.id_inst", id_inst, rom(mpc));
            end
            if (r_rspv) mem_out = 1'b0;
            if (imem_req_valid && r_rdy) begin
                mem_out  = 1'b1;
                mem_lat  = $urandom_range(0, 3);
                mem_data = rom(imem_req_addr);
            end
            if (r_redir) begin
                mpc = r_npc;
            end else if (id_valid && r_idr) begin
                mpc = r_npc;
                ndeliv++;
            end
        end
        chk("rnd.progress", 32'(ndeliv >= 50), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
